// File: rtl/factor_lister.sv
// Lists the divisors 2..19 of a captured operand, one per ready/valid handshake,
// and reports how many were listed plus whether the operand is prime.
module factor_lister (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_number,
  input  logic [17:0] i_factors,
  output logic [4:0]  o_div_data,
  output logic        o_div_valid,
  input  logic        i_div_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [4:0]  o_count,
  output logic        o_is_prime
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT, S_DONE} state_t;

  state_t      r_state, w_next_state;
  logic [7:0]  r_number, w_number;
  logic [17:0] r_factors, w_factors;
  logic [4:0]  r_idx, w_idx;
  logic        r_prime, w_prime;
  logic [4:0]  r_div_data, w_div_data;
  logic        r_div_valid, w_div_valid;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic [4:0]  r_count, w_count;
  logic        r_is_prime, w_is_prime;
  logic [4:0]  w_divisor;

  assign w_divisor = r_idx + 5'd2;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    w_next_state = r_state;
    w_number     = r_number;
    w_factors    = r_factors;
    w_idx        = r_idx;
    w_prime      = r_prime;
    w_div_data   = r_div_data;
    w_div_valid  = r_div_valid;
    w_count      = r_count;
    w_is_prime   = r_is_prime;
    w_done       = 1'b0;
    w_busy       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_number     = i_number;
          w_factors    = i_factors;
          w_idx        = 5'd0;
          w_count      = 5'd0;
          w_prime      = (i_number >= 8'd2);
          w_is_prime   = 1'b0;
          w_next_state = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_factors[r_idx]) begin
          w_div_data   = w_divisor;
          w_div_valid  = 1'b1;
          w_count      = r_count + 5'd1;
          w_next_state = S_EMIT;
          // Divisors up to 15 cover every composite below 256.
          if ((r_idx <= 5'd13) && ({3'b000, w_divisor} < r_number)) begin
            w_prime = 1'b0;
          end
        end else if (r_idx == 5'd17) begin
          w_next_state = S_DONE;
        end else begin
          w_idx = r_idx + 5'd1;
        end
      end
      S_EMIT: begin
        if (i_div_ready) begin
          w_div_valid = 1'b0;
          if (r_idx == 5'd17) begin
            w_next_state = S_DONE;
          end else begin
            w_idx        = r_idx + 5'd1;
            w_next_state = S_SCAN;
          end
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    if (w_next_state == S_DONE) begin
      w_done     = 1'b1;
      w_is_prime = r_prime;
    end
    w_busy = (w_next_state != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_number    <= 8'd0;
      r_factors   <= 18'd0;
      r_idx       <= 5'd0;
      r_prime     <= 1'b0;
      r_div_data  <= 5'd0;
      r_div_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= 5'd0;
      r_is_prime  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_number    <= w_number;
      r_factors   <= w_factors;
      r_idx       <= w_idx;
      r_prime     <= w_prime;
      r_div_data  <= w_div_data;
      r_div_valid <= w_div_valid;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_count     <= w_count;
      r_is_prime  <= w_is_prime;
    end
  end

  assign o_div_data  = r_div_data;
  assign o_div_valid = r_div_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_count     = r_count;
  assign o_is_prime  = r_is_prime;

endmodule

// File: tb/tb_factor_lister.sv
// Directed bench for factor_lister: listings with and without back-pressure,
// ignored mid-listing start, and reset in the middle of an emission.
module tb_factor_lister;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [7:0]  i_number;
  logic [17:0] i_factors;
  logic [4:0]  o_div_data;
  logic        o_div_valid;
  logic        i_div_ready;
  logic        o_busy;
  logic        o_done;
  logic [4:0]  o_count;
  logic        o_is_prime;

  int totalChecks = 0;
  int badChecks   = 0;

  factor_lister dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_number    (i_number),
    .i_factors   (i_factors),
    .o_div_data  (o_div_data),
    .o_div_valid (o_div_valid),
    .i_div_ready (i_div_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_count     (o_count),
    .o_is_prime  (o_is_prime)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    assert (observed === expected) else begin
      badChecks++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents one start pulse; returns at the falling edge of the first cycle after capture.
  task automatic applyStimulus(input logic [7:0] num, input logic [17:0] fac);
    i_number  = num;
    i_factors = fac;
    i_start   = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Runs a listing with div_ready held high and checks order, spacing, timing and results.
  task automatic runListing(input logic [7:0] num, input logic [17:0] fac,
                            input int expCount, input logic expPrime, input string tag);
    int cycle;
    int doneCycle;
    int bitPos;
    int nEmit;
    logic prevValid;
    i_div_ready = 1'b1;
    applyStimulus(num, fac);
    checkOutput({tag, "_busy_start"}, o_busy, 1);
    cycle = 1;
    doneCycle = -1;
    bitPos = 0;
    nEmit = 0;
    prevValid = 1'b0;
    while (cycle < 80 && doneCycle < 0) begin
      if (o_div_valid) begin
        while (bitPos < 18 && !fac[bitPos]) bitPos++;
        checkOutput({tag, "_div"}, o_div_data, bitPos + 2);
        checkOutput({tag, "_gap"}, prevValid, 0);
        bitPos++;
        nEmit++;
      end
      if (o_done) begin
        doneCycle = cycle;
      end else begin
        prevValid = o_div_valid;
        @(negedge i_clk);
        cycle++;
      end
    end
    checkOutput({tag, "_done_cycle"}, doneCycle, 19 + $countones(fac));
    checkOutput({tag, "_emissions"}, nEmit, expCount);
    checkOutput({tag, "_count"}, o_count, expCount);
    checkOutput({tag, "_prime"}, o_is_prime, expPrime);
    checkOutput({tag, "_busy_done"}, o_busy, 1);
    @(negedge i_clk);
    checkOutput({tag, "_done_pulse"}, o_done, 0);
    checkOutput({tag, "_busy_idle"}, o_busy, 0);
    @(negedge i_clk);
    checkOutput({tag, "_count_held"}, o_count, expCount);
  endtask

  initial begin
    int waitCycles;
    int emitted[$];
    int bpExp[3];
    bpExp = '{2, 3, 6};

    i_reset     = 1'b1;
    i_start     = 1'b0;
    i_number    = 8'd0;
    i_factors   = 18'd0;
    i_div_ready = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_valid", o_div_valid, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_count", o_count, 0);
    checkOutput("rst_data", o_div_data, 0);
    checkOutput("rst_prime", o_is_prime, 0);
    i_reset = 1'b0;
    @(negedge i_clk);

    runListing(8'd12, 18'h00417, 5, 1'b0, "n12");
    runListing(8'd13, 18'h00800, 1, 1'b1, "n13");
    runListing(8'd1,  18'h00000, 0, 1'b0, "n1");
    runListing(8'd0,  18'h3FFFF, 18, 1'b0, "n0");

    // Back-pressure on divisor 2 with a start pulse that must be ignored.
    i_div_ready = 1'b0;
    applyStimulus(8'd6, 18'h00013);
    waitCycles = 0;
    while (!o_div_valid && waitCycles < 30) begin
      @(negedge i_clk);
      waitCycles++;
    end
    checkOutput("bp_valid_seen", o_div_valid, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_data", o_div_data, 2);
      checkOutput("bp_hold_valid", o_div_valid, 1);
      if (i == 2) begin
        i_start   = 1'b1;
        i_number  = 8'd13;
        i_factors = 18'h00800;
      end else begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
    end
    i_start = 1'b0;
    i_div_ready = 1'b1;
    waitCycles = 0;
    while (!o_done && waitCycles < 40) begin
      if (o_div_valid) emitted.push_back(int'(o_div_data));
      @(negedge i_clk);
      waitCycles++;
    end
    checkOutput("bp_done", o_done, 1);
    checkOutput("bp_emit_count", emitted.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < emitted.size()) checkOutput("bp_emit_value", emitted[i], bpExp[i]);
    end
    checkOutput("bp_count", o_count, 3);
    checkOutput("bp_prime", o_is_prime, 0);
    @(negedge i_clk);
    checkOutput("bp_idle", o_busy, 0);

    // Reset while a divisor is waiting for acceptance.
    i_div_ready = 1'b0;
    applyStimulus(8'd12, 18'h00417);
    waitCycles = 0;
    while (!o_div_valid && waitCycles < 30) begin
      @(negedge i_clk);
      waitCycles++;
    end
    checkOutput("mid_valid_seen", o_div_valid, 1);
    i_reset = 1'b1;
    @(negedge i_clk);
    checkOutput("mid_rst_valid", o_div_valid, 0);
    checkOutput("mid_rst_busy", o_busy, 0);
    checkOutput("mid_rst_count", o_count, 0);
    checkOutput("mid_rst_data", o_div_data, 0);
    i_reset = 1'b0;
    i_div_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    checkOutput("mid_no_resume_busy", o_busy, 0);
    checkOutput("mid_no_resume_valid", o_div_valid, 0);
    runListing(8'd12, 18'h00417, 5, 1'b0, "afresh");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/factor_lister.md
FACTOR_LISTER -- requirements
Module: factor_lister

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset; one clock; all state sampled on rising clk.
REQ-003 SHALL have port start  input  1  request to capture and list one factor vector.
REQ-004 SHALL have port number  input  8  operand whose divisibility flags are on factors.
REQ-005 SHALL have port factors  input  18  divisibility flags; bit k set = number divisible by k+2 (bit 0 = 2 ... bit 17 = 19).
REQ-006 SHALL have port div_data  output  5  current divisor value (2..19).
REQ-007 SHALL have port div_valid  output  1  div_data holds a valid divisor.
REQ-008 SHALL have port div_ready  input  1  consumer accepts div_data when high with div_valid.
REQ-009 SHALL have port busy  output  1  high from capture until done cycle inclusive.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of listing.
REQ-011 SHALL have port count  output  5  number of divisors emitted in the current or last listing (0..18).
REQ-012 SHALL have port is_prime  output  1  primality of the captured number, valid while done is high and held until the next start.

Function
REQ-013 SHALL implement states IDLE, SCAN, EMIT, DONE; all outputs SHALL be registered.
REQ-014 In IDLE, start=1 at an edge SHALL capture number and factors into internal registers, clear count and scan index to 0, preset prime-candidate to (number >= 2), and go to SCAN.
REQ-015 start SHALL be ignored in every state except IDLE; captured values SHALL NOT change during a listing.
REQ-016 In SCAN, each edge SHALL examine captured bit idx: if clear and idx < 17, increment idx and stay in SCAN; if clear and idx = 17, go to DONE.
REQ-017 If the examined bit is set, the same edge SHALL load div_data = idx + 2, set div_valid, increment count, and go to EMIT.
REQ-018 If the set bit has divisor d with d <= 15 and d < captured number, the same edge SHALL clear prime-candidate.
REQ-019 In EMIT, div_data and div_valid SHALL hold stable until an edge with div_ready = 1.
REQ-020 On that edge, div_valid SHALL clear; the block SHALL go to DONE if idx = 17, else increment idx and return to SCAN.
REQ-021 Each set bit SHALL be emitted exactly once, in ascending divisor order; back-to-back emissions SHALL be separated by at least one SCAN cycle.
REQ-022 DONE SHALL last exactly one cycle with done = 1 and is_prime = prime-candidate, then go to IDLE.
REQ-023 busy SHALL be 1 in SCAN, EMIT and DONE, and 0 in IDLE.
REQ-024 With no back-pressure, the listing SHALL take 18 + (set-bit count) edges after the capture edge; done SHALL be high in the cycle after that.
REQ-025 div_ready while div_valid = 0 SHALL have no effect.
REQ-026 count SHALL hold its last value in IDLE until the next capture.

Reset
REQ-027 reset SHALL force IDLE at the next edge, from any state including mid-EMIT; it overrides start.
REQ-028 On reset, div_valid, busy, done, is_prime, count, div_data, the scan index and the captured registers SHALL all become 0.
REQ-029 Reset during EMIT SHALL drop div_valid without requiring a handshake; no partial listing SHALL resume afterward.

Verification
REQ-030 Verify: number=12, factors=0x00417, div_ready=1 -> emits 2,3,4,6,12 in order; done then count=5, is_prime=0.
REQ-031 Verify: number=13, factors=0x00800 -> single emission 13; count=1, is_prime=1; done high in the 20th cycle after capture.
REQ-032 Verify: number=1, factors=0 -> no div_valid; done high 19 cycles after capture; count=0, is_prime=0.
REQ-033 Verify: number=0, factors=0x3FFFF -> 18 emissions 2..19; count=18, is_prime=0.
REQ-034 Verify: number=6, factors=0x00013, div_ready held low 5 cycles on divisor 2 -> div_data=2 and div_valid stable throughout; then 3,6 follow; start pulsed mid-listing is ignored.
REQ-035 Verify: reset asserted while div_valid=1 -> next cycle div_valid=0, busy=0, count=0; a subsequent start lists afresh from divisor 2.
